// File: rtl/jtag_boot_seq_if.sv
// Pin bundle between the test top and the JTAG boot sequencer:
// sequencer control/status plus the four-wire TAP side.
interface jtag_boot_seq_if #(
  parameter int DR_WIDTH = 32
);
  logic                start_i;
  logic [DR_WIDTH-1:0] boot_addr_i;
  logic                busy_o;
  logic                done_o;
  logic                fetch_enable_o;
  logic [DR_WIDTH-1:0] dr_capture_o;
  logic                trstn_o;
  logic                tms_o;
  logic                tdi_o;
  logic                tdo_i;

  modport slave (
    input  start_i, boot_addr_i, tdo_i,
    output busy_o, done_o, fetch_enable_o, dr_capture_o, trstn_o, tms_o, tdi_o
  );

  modport master (
    output start_i, boot_addr_i, tdo_i,
    input  busy_o, done_o, fetch_enable_o, dr_capture_o, trstn_o, tms_o, tdi_o
  );
endinterface

// File: rtl/jtag_boot_seq.sv
// Post-reset TAP sequencer: TRST, Test-Logic-Reset, IR load, DR load/capture,
// back to Run-Test/Idle, then release the core via fetch_enable_o.
module jtag_boot_seq #(
  parameter int                  IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] IR_CODE     = 4'b1000,
  parameter int                  DR_WIDTH    = 32,
  parameter int                  TRST_CYCLES = 4,
  parameter bit                  AUTO_FETCH  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  jtag_boot_seq_if.slave  bus
);

  localparam int CMAX_A = (DR_WIDTH > TRST_CYCLES) ? DR_WIDTH : TRST_CYCLES;
  localparam int CMAX   = (CMAX_A > 5) ? CMAX_A : 5;
  localparam int CW     = $clog2(CMAX);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t TRST_LAST = cnt_t'(TRST_CYCLES - 1);
  localparam cnt_t IR_LAST   = cnt_t'(IR_WIDTH - 1);
  localparam cnt_t DR_LAST   = cnt_t'(DR_WIDTH - 1);
  localparam cnt_t C0        = cnt_t'(0);
  localparam cnt_t C1        = cnt_t'(1);
  localparam cnt_t C2        = cnt_t'(2);
  localparam cnt_t C4        = cnt_t'(4);

  // Phases are encoded in run order so the sequencer advances by increment.
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_TRST  = 4'd1;
  localparam logic [3:0] S_TLR   = 4'd2;
  localparam logic [3:0] S_GOIR  = 4'd3;
  localparam logic [3:0] S_SHIR  = 4'd4;
  localparam logic [3:0] S_ENDIR = 4'd5;
  localparam logic [3:0] S_GODR  = 4'd6;
  localparam logic [3:0] S_SHDR  = 4'd7;
  localparam logic [3:0] S_ENDDR = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  logic [3:0]          state_q, state_d;
  cnt_t                cnt_q, cnt_d;
  logic [DR_WIDTH-1:0] addr_q, addr_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic                trstn_q, trstn_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fetch_q, fetch_d;
  logic                launch;
  logic [IR_WIDTH-1:0] ir_sh;
  logic [DR_WIDTH-1:0] dr_sh;

  function automatic cnt_t phase_last(input logic [3:0] s);
    cnt_t r;
    r = C0;
    case (s)
      S_TRST:          r = TRST_LAST;
      S_TLR, S_GOIR:   r = C4;
      S_SHIR:          r = IR_LAST;
      S_ENDIR,S_ENDDR: r = C1;
      S_GODR:          r = C2;
      S_SHDR:          r = DR_LAST;
      default:         r = C0;
    endcase
    return r;
  endfunction

  always_comb begin
    launch  = (state_q == S_IDLE) && bus.start_i;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = C0;
        if (launch) state_d = S_TRST;
      end
      S_DONE: begin
        cnt_d   = C0;
        state_d = S_IDLE;
      end
      default: begin
        if (cnt_q == phase_last(state_q)) begin
          state_d = state_q + 4'd1;
          cnt_d   = C0;
        end else begin
          cnt_d = cnt_q + C1;
        end
      end
    endcase

    // Pin values are a function of the phase being entered, so the
    // registered outputs line up with state_q/cnt_q one cycle later.
    ir_sh   = IR_CODE >> cnt_d;
    dr_sh   = addr_q >> cnt_d;
    trstn_d = (state_d != S_TRST);
    tms_d   = 1'b1;
    tdi_d   = 1'b0;
    case (state_d)
      S_GOIR:  tms_d = (cnt_d == C1) || (cnt_d == C2);
      S_SHIR: begin
        tms_d = (cnt_d == IR_LAST);
        tdi_d = ir_sh[0];
      end
      S_ENDIR, S_GODR, S_ENDDR: tms_d = (cnt_d == C0);
      S_SHDR: begin
        tms_d = (cnt_d == DR_LAST);
        tdi_d = dr_sh[0];
      end
      S_FIN:   tms_d = 1'b0;
      default: tms_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);

    addr_d = launch ? bus.boot_addr_i : addr_q;

    fetch_d = fetch_q;
    if (launch)                fetch_d = 1'b0;
    else if (state_d == S_DONE) fetch_d = AUTO_FETCH;

    // TDO is sampled on the edge that closes each Shift-DR cycle.
    cap_d = cap_q;
    if (launch)                 cap_d = '0;
    else if (state_q == S_SHDR) cap_d = {bus.tdo_i, cap_q[DR_WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= C0;
      addr_q  <= '0;
      cap_q   <= '0;
      trstn_q <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cap_q   <= cap_d;
      trstn_q <= trstn_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fetch_q <= fetch_d;
    end
  end

  assign bus.trstn_o        = trstn_q;
  assign bus.tms_o          = tms_q;
  assign bus.tdi_o          = tdi_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.fetch_enable_o = fetch_q;
  assign bus.dr_capture_o   = cap_q;

endmodule

// File: tb/tb_jtag_boot_seq.sv
// Directed bench for jtag_boot_seq with a behavioural TAP on the JTAG pins
// and a second instance built with AUTO_FETCH=0.
module tb_jtag_boot_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] boot = '0;
  logic [31:0] preload = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  jtag_boot_seq_if #(.DR_WIDTH(32)) if1 ();
  jtag_boot_seq_if #(.DR_WIDTH(32)) if0 ();

  logic [31:0] tap_dr = '0;
  logic [3:0]  tap_ir = '0;
  logic [3:0]  ir_got = '0;
  logic [31:0] dr_got = '0;
  int          ts = 0;
  int          done_cnt = 0;
  int          done0_cnt = 0;
  logic        fe0_seen = 1'b0;

  assign if1.start_i     = start;
  assign if1.boot_addr_i = boot;
  assign if1.tdo_i       = tap_dr[0];
  assign if0.start_i     = start;
  assign if0.boot_addr_i = boot;
  assign if0.tdo_i       = 1'b0;

  jtag_boot_seq dut (.clk(clk), .rst_n(rst_n), .bus(if1));
  jtag_boot_seq #(.AUTO_FETCH(1'b0)) dut_nf (.clk(clk), .rst_n(rst_n), .bus(if0));

  localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHDR = 4, T_E1DR = 5,
                 T_PDR = 6, T_E2DR = 7, T_UDR = 8, T_SIR = 9, T_CIR = 10, T_SHIR = 11,
                 T_E1IR = 12, T_PIR = 13, T_E2IR = 14, T_UIR = 15;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      T_UIR:  return m ? T_SDR  : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  // Reference TAP: loopback DR preloaded at Capture-DR.
  always @(posedge clk) begin
    if (!if1.trstn_o) begin
      ts <= T_TLR;
    end else begin
      case (ts)
        T_CIR:  tap_ir <= 4'b0001;
        T_SHIR: tap_ir <= {if1.tdi_o, tap_ir[3:1]};
        T_UIR:  ir_got <= tap_ir;
        T_CDR:  tap_dr <= preload;
        T_SHDR: tap_dr <= {if1.tdi_o, tap_dr[31:1]};
        T_UDR:  dr_got <= tap_dr;
        default: ;
      endcase
      ts <= tap_next(ts, if1.tms_o);
    end
  end

  always @(negedge clk) begin
    if (if1.done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (if0.done_o === 1'b1) done0_cnt <= done0_cnt + 1;
    if (if0.fetch_enable_o === 1'b1) fe0_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (if1.done_o === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({if1.trstn_o, if1.tms_o, if1.tdi_o, if1.busy_o, if1.done_o, if1.fetch_enable_o} !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_pins: got %b expected 010000",
               {if1.trstn_o, if1.tms_o, if1.tdi_o, if1.busy_o, if1.done_o, if1.fetch_enable_o});
    end
    n_chk++;
    if (if1.dr_capture_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_capture: got %h expected 00000000", if1.dr_capture_o);
    end
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({if1.trstn_o, if1.tms_o, if1.tdi_o, if1.busy_o} !== 4'b1100) begin
      n_fail++;
      $display("FAIL idle_pins: got %b expected 1100", {if1.trstn_o, if1.tms_o, if1.tdi_o, if1.busy_o});
    end
  endtask

  task automatic test_boot();
    logic [56:0] tms_v, trst_v;
    logic [56:0] exp_tms;
    logic        busy_all;
    exp_tms  = {4'b1111, 5'b11111, 5'b01100, 4'b0001, 2'b10, 3'b100, 32'h0000_0001, 2'b10};
    busy_all = 1'b1;
    tms_v    = '0;
    trst_v   = '0;
    preload  = 32'hA5A5_1234;
    start    = 1'b1;
    boot     = 32'h0000_8000;
    tick();
    start = 1'b0;
    boot  = 32'hDEAD_BEEF;
    for (int k = 0; k <= 56; k++) begin
      tms_v    = {tms_v[55:0], if1.tms_o};
      trst_v   = {trst_v[55:0], if1.trstn_o};
      busy_all = busy_all & if1.busy_o;
      if (k < 56) tick();
    end
    n_chk++;
    if (tms_v !== exp_tms) begin
      n_fail++;
      $display("FAIL tms_stream: got %b expected %b", tms_v, exp_tms);
    end
    n_chk++;
    if (trst_v !== {4'b0000, {53{1'b1}}}) begin
      n_fail++;
      $display("FAIL trstn_stream: got %b", trst_v);
    end
    n_chk++;
    if (busy_all !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_window: busy dropped during run");
    end
    tick();
    n_chk++;
    if ({if1.busy_o, if1.done_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL e57_busy_done: got %b expected 10", {if1.busy_o, if1.done_o});
    end
    tick();
    n_chk++;
    if ({if1.busy_o, if1.done_o, if1.fetch_enable_o} !== 3'b011) begin
      n_fail++;
      $display("FAIL e58_busy_done_fetch: got %b expected 011", {if1.busy_o, if1.done_o, if1.fetch_enable_o});
    end
    n_chk++;
    if (ir_got !== 4'b1000) begin
      n_fail++;
      $display("FAIL tap_ir: got %b expected 1000", ir_got);
    end
    n_chk++;
    if (dr_got !== 32'h0000_8000) begin
      n_fail++;
      $display("FAIL tap_dr: got %h expected 00008000", dr_got);
    end
    n_chk++;
    if (if1.dr_capture_o !== 32'hA5A5_1234) begin
      n_fail++;
      $display("FAIL dr_capture: got %h expected a5a51234", if1.dr_capture_o);
    end
    n_chk++;
    if ({if0.done_o, if0.fetch_enable_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL nofetch_done: got %b expected 10", {if0.done_o, if0.fetch_enable_o});
    end
    tick();
    n_chk++;
    if ({if1.done_o, if1.fetch_enable_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL e59_done_fetch: got %b expected 01", {if1.done_o, if1.fetch_enable_o});
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    d0      = done_cnt;
    preload = 32'h1357_9BDF;
    start   = 1'b1;
    boot    = 32'h1111_0000;
    tick();
    for (int k = 1; k <= 62; k++) begin
      start = (k == 10) || (k == 56) || (k == 59);
      boot  = 32'h2222_0000 + 32'(k);
      tick();
    end
    start = 1'b0;
    n_chk++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - d0);
    end
    n_chk++;
    if (dr_got !== 32'h1111_0000) begin
      n_fail++;
      $display("FAIL ignore_tap_dr: got %h expected 11110000", dr_got);
    end
    n_chk++;
    if (if1.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_restart: busy got %b expected 0", if1.busy_o);
    end
    n_chk++;
    if (if1.dr_capture_o !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL ignore_capture: got %h expected 13579bdf", if1.dr_capture_o);
    end
  endtask

  task automatic test_reset_mid();
    int d0, cyc;
    d0      = done_cnt;
    preload = 32'h0F0F_0F0F;
    start   = 1'b1;
    boot    = 32'h3333_4444;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 29; k++) tick();
    rst_n = 1'b0;
    tick();
    n_chk++;
    if ({if1.trstn_o, if1.tms_o, if1.tdi_o, if1.busy_o, if1.done_o, if1.fetch_enable_o} !== 6'b010000) begin
      n_fail++;
      $display("FAIL midreset_pins: got %b expected 010000",
               {if1.trstn_o, if1.tms_o, if1.tdi_o, if1.busy_o, if1.done_o, if1.fetch_enable_o});
    end
    n_chk++;
    if (if1.dr_capture_o !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_capture: got %h expected 00000000", if1.dr_capture_o);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({if1.trstn_o, if1.busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_beats_start: got %b expected 10", {if1.trstn_o, if1.busy_o});
    end
    for (int k = 0; k < 60; k++) tick();
    n_chk++;
    if (done_cnt !== d0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d expected %0d", done_cnt, d0);
    end
    preload = 32'hCAFE_F00D;
    start   = 1'b1;
    boot    = 32'h0000_1000;
    tick();
    start = 1'b0;
    wait_done(cyc);
    n_chk++;
    if (cyc !== 58) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d expected 58", cyc);
    end
    n_chk++;
    if ({dr_got, if1.dr_capture_o} !== {32'h0000_1000, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL post_reset_dr: got %h/%h expected 00001000/cafef00d", dr_got, if1.dr_capture_o);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    tick();
    n_chk++;
    if ({if1.done_o, if1.fetch_enable_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_pre: got %b expected 01", {if1.done_o, if1.fetch_enable_o});
    end
    preload = 32'h5A5A_0001;
    start   = 1'b1;
    boot    = 32'h0000_2000;
    tick();
    start = 1'b0;
    n_chk++;
    if ({if1.busy_o, if1.fetch_enable_o, if1.trstn_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_e0: got %b expected 100", {if1.busy_o, if1.fetch_enable_o, if1.trstn_o});
    end
    wait_done(cyc);
    n_chk++;
    if (cyc !== 58) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d expected 58", cyc);
    end
    n_chk++;
    if ({if1.fetch_enable_o, dr_got, if1.dr_capture_o} !== {1'b1, 32'h0000_2000, 32'h5A5A_0001}) begin
      n_fail++;
      $display("FAIL b2b_result: got %b %h %h expected 1 00002000 5a5a0001",
               if1.fetch_enable_o, dr_got, if1.dr_capture_o);
    end
  endtask

  task automatic test_no_autofetch();
    tick();
    tick();
    n_chk++;
    if (done0_cnt !== 4) begin
      n_fail++;
      $display("FAIL nofetch_done_count: got %0d expected 4", done0_cnt);
    end
    n_chk++;
    if (fe0_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL nofetch_fetch: fetch_enable_o seen %b expected 0", fe0_seen);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_no_autofetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
